// File: rtl/neopix_frame_sequencer_pkg.sv
// Shared definitions for the WS2812B frame sequencer and its serializer.
// This package holds the sequencer state encoding, the colour-order helper,
// and the bit timing constants that both stages agree on.
package neopix_frame_sequencer_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  // WS2812B line timing, expressed in cycles of a 16 MHz clock.
  localparam int CLK_HZ            = 16_000_000;
  localparam int T0H_TICKS         = 6;    // ~0.40 us high for a '0' bit
  localparam int T1H_TICKS         = 13;   // ~0.80 us high for a '1' bit
  localparam int BIT_TICKS         = 20;   // 1.25 us total bit period
  localparam int RESET_TICKS_50US  = 800;  // 50 us low line latches the frame

  // The host writes {R,G,B}; the LED chain expects G first, then R, then B.
  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/neopix_frame_sequencer_if.sv
// Pixel stream between the frame sequencer and the bit serializer.
// The sequencer (master) offers one GRB word at a time with valid/ready; the
// serializer (slave) also reports when its output line has gone idle.
interface neopix_frame_sequencer_if;
  logic [23:0] pix_dat;
  logic        pix_valid;
  logic        pix_ready;
  logic        ser_idle;

  modport master (
    output pix_dat,
    output pix_valid,
    input  pix_ready,
    input  ser_idle
  );

  modport slave (
    input  pix_dat,
    input  pix_valid,
    output pix_ready,
    output ser_idle
  );
endinterface

// File: rtl/neopix_frame_sequencer_pixel_ram.sv
// Simple dual-port frame buffer with a registered read port.
// Read-before-write: a read and a write to the same address in one cycle
// return the previous contents. The array has no reset so it maps onto block
// RAM, and the frame survives a reset of the control logic.
module neopix_frame_sequencer_pixel_ram #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];
  logic [DATA_W-1:0] rd_data_q;

  // Write port and registered read port; the read sees pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/neopix_frame_sequencer.sv
// WS2812B frame sequencer: holds NUM_PIXELS colours written by the host and,
// on start, streams them in GRB order to the serializer one word at a time.
// After the last word it waits for the serializer to go idle, then holds the
// line low for RESET_TICKS cycles before pulsing frame_done.
module neopix_frame_sequencer
  import neopix_frame_sequencer_pkg::*;
#(
  parameter  int NUM_PIXELS  = 8,
  parameter  int RESET_TICKS = 800,
  localparam int ADDR_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [23:0]             wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  neopix_frame_sequencer_if.master pix_if
);

  localparam int CNT_W = $clog2(RESET_TICKS + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(RESET_TICKS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_done_q, frame_done_d;

  logic              wr_in_range;
  logic              rd_en;
  logic [23:0]       rd_data;
  logic              xfer;

  // Drop host writes that point past the last pixel. When NUM_PIXELS fills
  // the address space every address is valid and no compare is needed.
  generate
    if (NUM_PIXELS == (1 << ADDR_W)) begin : g_addr_full
      assign wr_in_range = 1'b1;
    end else begin : g_addr_part
      assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_PIXELS));
    end
  endgenerate

  // The buffer is read only in LOAD, so its output register holds the
  // current pixel steady for the whole SEND phase, however long it stalls.
  assign rd_en = (state_q == ST_LOAD);

  neopix_frame_sequencer_pixel_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (24)
  ) u_pixel_ram (
    .clk     (clk),
    .wr_en   (wr_en && wr_in_range),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  // Stream outputs: valid only in SEND; data forced to zero otherwise so the
  // unreset RAM output never leaks onto the bus.
  assign pix_if.pix_valid = (state_q == ST_SEND);
  assign pix_if.pix_dat   = (state_q == ST_SEND) ? rgb_to_grb(rd_data) : 24'h000000;
  assign xfer             = (state_q == ST_SEND) && pix_if.pix_ready;

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

  // Next-state logic: walk the pixels, drain the serializer, time the latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end

      ST_LOAD: begin
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end

      ST_DRAIN: begin
        if (pix_if.ser_idle) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end
      end

      ST_LATCH: begin
        if (cnt_q == LAST_TICK) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_neopix_frame_sequencer.sv
// Directed bench for the WS2812B frame sequencer with a 3-pixel frame and the
// default 800-cycle latch gap.
module tb_neopix_frame_sequencer;

  localparam int NP = 3;
  localparam int RT = 800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic        start;
  logic        busy;
  logic        frame_done;

  neopix_frame_sequencer_if pif ();

  neopix_frame_sequencer #(
    .NUM_PIXELS  (NP),
    .RESET_TICKS (RT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_if     (pif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] cap [0:2];
  int cap_n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Record every accepted word until n have been taken (bounded).
  task automatic collect(input int n);
    cap_n = 0;
    for (int i = 0; i < 300 && cap_n < n; i++) begin
      if (pif.pix_valid && pif.pix_ready) begin
        cap[cap_n] = pif.pix_dat;
        cap_n++;
      end
      tick();
    end
    checks++;
    if (cap_n !== n) begin
      errors++;
      $display("FAIL collect_count: got %0d transfers, expected %0d", cap_n, n);
    end
  endtask

  // Count edges until frame_done is seen; -1 when the bound expires.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (frame_done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    pif.pix_ready = 1'b0; pif.ser_idle = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || pif.pix_valid !== 1'b0 || pif.pix_dat !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b valid=%b dat=%h, expected 0 0 0 000000",
               busy, frame_done, pif.pix_valid, pif.pix_dat);
    end
  endtask

  task automatic test_basic_frame();
    int cyc;
    wr_px(2'd0, 24'hFF0000);
    wr_px(2'd1, 24'h00FF00);
    wr_px(2'd2, 24'h0000FF);
    pif.pix_ready = 1'b1; pif.ser_idle = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || pif.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_load: busy=%b valid=%b, expected 1 0", busy, pif.pix_valid);
    end
    tick();
    checks++;
    if (pif.pix_valid !== 1'b1 || pif.pix_dat !== 24'h00FF00) begin
      errors++;
      $display("FAIL basic_px0: valid=%b dat=%h, expected 1 00ff00", pif.pix_valid, pif.pix_dat);
    end
    tick();
    checks++;
    if (pif.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_bubble: valid=%b, expected 0", pif.pix_valid);
    end
    tick();
    checks++;
    if (pif.pix_valid !== 1'b1 || pif.pix_dat !== 24'hFF0000) begin
      errors++;
      $display("FAIL basic_px1: valid=%b dat=%h, expected 1 ff0000", pif.pix_valid, pif.pix_dat);
    end
    tick();
    tick();
    checks++;
    if (pif.pix_valid !== 1'b1 || pif.pix_dat !== 24'h0000FF) begin
      errors++;
      $display("FAIL basic_px2: valid=%b dat=%h, expected 1 0000ff", pif.pix_valid, pif.pix_dat);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || pif.pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: busy=%b valid=%b done=%b, expected 1 0 0", busy, pif.pix_valid, frame_done);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== RT + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latch_len: cycles=%0d busy=%b, expected %0d 0", cyc, busy, RT + 1);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b, expected 0 0", frame_done, busy);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    logic [23:0] last;
    pif.pix_ready = 1'b0; pif.ser_idle = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ok = 1'b1;
    last = pif.pix_dat;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pif.pix_valid !== 1'b1 || pif.pix_dat !== 24'h00FF00) begin
        ok = 1'b0;
        last = pif.pix_dat;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_hold: dat=%h, expected stable 00ff00 with valid=1", last);
    end
    pif.pix_ready = 1'b1;
    tick();
    pif.pix_ready = 1'b0;
    checks++;
    if (pif.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single_xfer: valid=%b, expected 0", pif.pix_valid);
    end
    tick();
    checks++;
    if (pif.pix_valid !== 1'b1 || pif.pix_dat !== 24'hFF0000) begin
      errors++;
      $display("FAIL bp_next_px: valid=%b dat=%h, expected 1 ff0000", pif.pix_valid, pif.pix_dat);
    end
    pif.pix_ready = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL bp_done: no frame_done within bound, expected one");
    end
    tick();
  endtask

  task automatic test_drain();
    int cyc;
    bit ok;
    pif.pix_ready = 1'b1; pif.ser_idle = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(3);
    checks++;
    if (cap[0] !== 24'h00FF00 || cap[1] !== 24'hFF0000 || cap[2] !== 24'h0000FF) begin
      errors++;
      $display("FAIL drain_data: got %h %h %h, expected 00ff00 ff0000 0000ff", cap[0], cap[1], cap[2]);
    end
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1 || pif.pix_valid !== 1'b0 || frame_done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_hold: busy=%b done=%b, expected to stay busy in drain", busy, frame_done);
    end
    pif.ser_idle = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc !== RT + 1) begin
      errors++;
      $display("FAIL drain_latch_len: cycles=%0d, expected %0d", cyc, RT + 1);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    int extra;
    pif.pix_ready = 1'b1; pif.ser_idle = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL busy_start_done: no frame_done within bound, expected one");
    end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (frame_done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start_ignored: %0d busy/done cycles after frame, expected 0", extra);
    end
    start = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc < 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_idle: cycles=%0d busy=%b, expected done with busy 0", cyc, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || pif.pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload: busy=%b valid=%b done=%b, expected 1 0 0", busy, pif.pix_valid, frame_done);
    end
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL b2b_second_done: no frame_done within bound, expected one");
    end
    tick();
  endtask

  task automatic test_write_during_frame();
    int cyc;
    wr_px(2'd1, 24'h445566);
    wr_px(2'd2, 24'h778899);
    pif.pix_ready = 1'b0; pif.ser_idle = 1'b1;
    // start together with a write to pixel 0: the new colour must be used
    start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'hABCDEF;
    tick();
    start = 1'b0; wr_en = 1'b0;
    tick();
    wr_px(2'd2, 24'hDDEEFF);  // not yet loaded: shows up this frame
    wr_px(2'd0, 24'h010203);  // already loaded: shows up next frame
    wr_px(2'd3, 24'h5A5A5A);  // out of range: dropped
    pif.pix_ready = 1'b1;
    collect(3);
    checks++;
    if (cap[0] !== 24'hCDABEF || cap[1] !== 24'h554466 || cap[2] !== 24'hEEDDFF) begin
      errors++;
      $display("FAIL wr_same_frame: got %h %h %h, expected cdabef 554466 eeddff", cap[0], cap[1], cap[2]);
    end
    wait_done(cyc);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(3);
    checks++;
    if (cap[0] !== 24'h020103 || cap[1] !== 24'h554466 || cap[2] !== 24'hEEDDFF) begin
      errors++;
      $display("FAIL wr_next_frame: got %h %h %h, expected 020103 554466 eeddff", cap[0], cap[1], cap[2]);
    end
    wait_done(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL wr_done: no frame_done within bound, expected one");
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    bit ok;
    pif.pix_ready = 1'b0; pif.ser_idle = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || pif.pix_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: busy=%b valid=%b done=%b, expected 0 0 0", busy, pif.pix_valid, frame_done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || frame_done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_stay_idle: busy=%b done=%b, expected 0 0", busy, frame_done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (pif.pix_valid !== 1'b1 || pif.pix_dat !== 24'h020103) begin
      errors++;
      $display("FAIL rst_ram_kept: valid=%b dat=%h, expected 1 020103", pif.pix_valid, pif.pix_dat);
    end
    pif.pix_ready = 1'b1;
    wait_done(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL rst_frame_done: no frame_done within bound, expected one");
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_drain();
    test_start_while_busy();
    test_write_during_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
